// File: rtl/multi_port_reg_file_if.sv
// Bus bundle for the multi-port register file: two read ports, one write port,
// clear request and status. The master drives addresses and data; the slave returns read data.
interface multi_port_reg_file_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] aWrite;
  logic [DATA_W-1:0] dataIn;
  logic              load;
  logic              clrReq;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              valid1;
  logic              valid2;
  logic              busy;

  modport master (
    output a1, a2, aWrite, dataIn, load, clrReq,
    input  out1, out2, valid1, valid2, busy
  );

  modport slave (
    input  a1, a2, aWrite, dataIn, load, clrReq,
    output out1, out2, valid1, valid2, busy
  );
endinterface

// File: rtl/multi_port_reg_file.sv
// Register file with two combinational read ports, one write port and per-entry valid bits.
// A clear sequence zeroes one entry per cycle. Optional write-to-read forwarding and a hardwired zero register.
module multi_port_reg_file #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 8,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_port_reg_file_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;

  logic [DATA_W-1:0] w_data  [DEPTH];
  logic              w_valid [DEPTH];
  logic              w_busy;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [DATA_W-1:0] w_rd    [2];
  logic              w_rd_v  [2];

  assign w_busy  = (r_state == CLEAR);
  // A write to the hardwired zero register must neither store nor forward.
  assign w_wr_en = bus.load && !w_busy && !(ZERO_REG && (bus.aWrite == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.clrReq) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_reg
      logic [DATA_W-1:0] r_data;
      logic              r_vld;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else if (w_busy && (r_ptr == ADDR_W'(gi))) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else if (w_wr_en && (bus.aWrite == ADDR_W'(gi))) begin
          r_data <= bus.dataIn;
          r_vld  <= 1'b1;
        end
      end

      assign w_data[gi]  = r_data;
      assign w_valid[gi] = r_vld;
    end

    assign w_addr[0] = bus.a1;
    assign w_addr[1] = bus.a2;

    for (gi = 0; gi < 2; gi++) begin : gen_rd
      logic [DATA_W-1:0] w_out;
      logic              w_out_v;

      always_comb begin
        w_out   = w_data[w_addr[gi]];
        w_out_v = w_valid[w_addr[gi]];
        if (ZERO_REG && (w_addr[gi] == '0)) begin
          w_out   = '0;
          w_out_v = 1'b1;
        end else if (BYPASS && w_wr_en && (w_addr[gi] == bus.aWrite)) begin
          w_out   = bus.dataIn;
          w_out_v = 1'b1;
        end
      end

      assign w_rd[gi]   = w_out;
      assign w_rd_v[gi] = w_out_v;
    end
  endgenerate

  assign bus.out1   = w_rd[0];
  assign bus.out2   = w_rd[1];
  assign bus.valid1 = w_rd_v[0];
  assign bus.valid2 = w_rd_v[1];
  assign bus.busy   = w_busy;
endmodule
